inst_buffer: RTL and testbench

//   Circular FIFO between fetch and decode. Absorbs fetch bursts and dispatch stalls.

---
 rtl/inst_buffer.sv | 97 +++++++++
 tb/tb_inst_buffer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// Circular instruction buffer between fetch and decode: a DEPTH-entry FIFO of fetch packets.
// Supports flush on mispredict and blocks further pushes once a WFI has been enqueued.
//
// Packet layout (PKT_W = 65): [64] valid, [63:32] pc, [31:0] inst.
module inst_buffer #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PKT_W = 65,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [PKT_W-1:0] in_packet,
    output logic             in_ready,
    output logic [PKT_W-1:0] out_packet,
    input  logic             dispatch_ready,
    output logic [CNT_W-1:0] count,
    output logic             halt_seen
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned DATA_W = PKT_W - 1;
    localparam logic [31:0] WFI_INST = 32'h1050_0073;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              halt_q, halt_d;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              push;
    logic              pop;
    logic              not_empty;

    assign in_valid  = in_packet[PKT_W-1];
    assign in_data   = in_packet[DATA_W-1:0];
    assign not_empty = (count_q != '0);

    // Ready ignores any same-cycle pop: a full buffer never passes a packet through.
    assign in_ready = (count_q < CNT_W'(DEPTH)) && !halt_q && !flush && !reset;
    assign push     = in_valid && in_ready;
    assign pop      = not_empty && dispatch_ready && !flush;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        halt_d  = halt_q;

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            halt_d  = 1'b0;
        end else begin
            if (push) begin
                mem_d[tail_q] = in_data;
                tail_d        = tail_q + PTR_W'(1);
                if (in_data[31:0] == WFI_INST) begin
                    halt_d = 1'b1;
                end
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            halt_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            halt_q  <= halt_d;
        end
    end

    // Storage needs no reset: contents are only observable while count is non-zero.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign out_packet = not_empty ? {1'b1, mem_q[head_q]} : '0;
    assign count      = count_q;
    assign halt_seen  = halt_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: the driver enqueues expected packets into a scoreboard,
// and an independent monitor checks every head packet the DUT pops.
module tb_inst_buffer;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] ADD  = 32'h0020_81b3;
    localparam logic [31:0] WFI  = 32'h1050_0073;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [64:0] in_packet = '0;
    logic        in_ready;
    logic [64:0] out_packet;
    logic        dispatch_ready = 1'b0;
    logic [3:0]  count;
    logic        halt_seen;

    int          n_checks = 0;
    int          n_fail = 0;
    logic        running = 1'b0;
    logic [31:0] pc_ctr = 32'h0000_1000;
    logic [63:0] exp_q [$];

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_packet      (in_packet),
        .in_ready       (in_ready),
        .out_packet     (out_packet),
        .dispatch_ready (dispatch_ready),
        .count          (count),
        .halt_seen      (halt_seen)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; in_ready/count/halt_seen are checked before the edge.
    task automatic step(input string tag, input logic pv, input logic [31:0] inst,
                        input logic dr, input logic fl, input logic exp_acc,
                        input int exp_cnt, input logic exp_halt);
        in_packet      = {pv, pc_ctr, inst};
        dispatch_ready = dr;
        flush          = fl;
        @(negedge clock);
        check({tag, " in_ready"}, 65'(in_ready), 65'(exp_acc));
        check({tag, " count"}, 65'(count), 65'(exp_cnt));
        check({tag, " halt_seen"}, 65'(halt_seen), 65'(exp_halt));
        @(posedge clock);
        if (fl) exp_q.delete();
        else if (pv && exp_acc) exp_q.push_back({pc_ctr, inst});
        pc_ctr += 32'd4;
        #1;
    endtask

    // Monitor: compares the head packet whenever the DUT is about to pop it.
    always @(negedge clock) begin
        if (running && !reset) begin
            check("out_valid", 65'(out_packet[64]), 65'(exp_q.size() != 0));
            if (!out_packet[64]) begin
                check("out_zero_when_empty", out_packet, 65'd0);
            end else if (dispatch_ready && !flush && exp_q.size() != 0) begin
                check("pop_data", 65'(out_packet[63:0]), 65'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset
        @(posedge clock);
        @(negedge clock);
        check("rst in_ready_low", 65'(in_ready), 65'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst count", 65'(count), 65'd0);
        check("rst out_packet", out_packet, 65'd0);
        check("rst halt_seen", 65'(halt_seen), 65'd0);
        check("rst in_ready", 65'(in_ready), 65'd1);
        @(posedge clock);
        #1;
        running = 1'b1;

        // T1: single push, visible the next cycle, popped immediately
        step("t1 push", 1'b1, ADDI, 1'b1, 1'b0, 1'b1, 0, 1'b0);
        step("t1 head", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        step("t1 empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // T2: fill to DEPTH with no dispatch, then a rejected 9th push
        for (int i = 0; i < 8; i++) begin
            step("t2 fill", 1'b1, 32'h0000_0013 | (32'(i) << 7), 1'b0, 1'b0, 1'b1, i, 1'b0);
        end
        step("t2 full", 1'b1, 32'hBAD0_0013, 1'b0, 1'b0, 1'b0, 8, 1'b0);

        // T3: push+pop while full -> push rejected, then drain to 4
        step("t3 full_pp", 1'b1, 32'hBAD1_0013, 1'b1, 1'b0, 1'b0, 8, 1'b0);
        step("t3 pop7", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 7, 1'b0);
        step("t3 pop6", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 6, 1'b0);
        step("t3 pop5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("t3 pushpop", 1'b1, 32'h0000_1033 | (32'(i) << 7), 1'b1, 1'b0, 1'b1, 4, 1'b0);
        end
        for (int i = 4; i > 0; i--) begin
            step("t3 drain", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, i, 1'b0);
        end
        step("t3 empty", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // T4: flush discards contents and same-cycle push/pop
        for (int i = 0; i < 3; i++) begin
            step("t4 fill", 1'b1, 32'h0000_2013 | (32'(i) << 7), 1'b0, 1'b0, 1'b1, i, 1'b0);
        end
        step("t4 flush", 1'b1, 32'hBAD2_0013, 1'b1, 1'b1, 1'b0, 3, 1'b0);
        step("t4 after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // T5: WFI fence
        step("t5 wfi", 1'b1, WFI, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        step("t5 add", 1'b1, ADD, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        step("t5 popwfi", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
        step("t5 drained", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 1'b1);
        step("t5 flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 0, 1'b1);
        step("t5 cleared", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        // T6: reset mid-stream with 5 entries and halt set
        for (int i = 0; i < 4; i++) begin
            step("t6 fill", 1'b1, 32'h0000_3013 | (32'(i) << 7), 1'b0, 1'b0, 1'b1, i, 1'b0);
        end
        step("t6 wfi", 1'b1, WFI, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        reset          = 1'b1;
        in_packet      = '0;
        dispatch_ready = 1'b0;
        @(negedge clock);
        check("t6 pre count", 65'(count), 65'd5);
        check("t6 pre halt", 65'(halt_seen), 65'd1);
        check("t6 pre in_ready", 65'(in_ready), 65'd0);
        @(posedge clock);
        exp_q.delete();
        #1;
        reset = 1'b0;
        step("t6 post", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        step("t6 push", 1'b1, ADDI, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        step("t6 pop", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1, 1'b0);
        step("t6 end", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        running = 1'b0;
        check("scoreboard drained", 65'(exp_q.size()), 65'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
